// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor fetch engine.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_START,
        ST_WAIT_DONE,
        ST_ERR
    } state_t;

    localparam int         DESC_WORDS = 5;
    localparam logic [3:0] DESC_ARLEN = 4'(DESC_WORDS - 1);

    localparam logic [3:0] SEL_SRC  = 4'd0;
    localparam logic [3:0] SEL_DST  = 4'd1;
    localparam logic [3:0] SEL_LEN  = 4'd2;
    localparam logic [3:0] SEL_NEXT = 4'd3;
    localparam logic [3:0] SEL_EOC  = 4'd4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dma_desc_fetch.sv
// Walks a linked list of 5-word DMA descriptors over AXI4 read bursts,
// loads each into the DMA register block and kicks the data-move engine.
module dma_desc_fetch
    import dma_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = ID_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DMAEN,
    input  logic [ADDR_W-1:0] DESC_BASE,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [DATA_W-1:0] DESC_input,
    output logic [3:0]        DESC_sel,
    output logic              DESC_write_en,
    output logic              Start,
    input  logic              Done,
    output logic              busy,
    output logic              err
);

    state_t            state;
    logic              dmaen_q;
    logic              err_flag;
    logic              err_now;
    logic              eoc;
    logic [3:0]        beat;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;

    logic unused_inputs;
    assign unused_inputs = ^{RID, DESC_BASE[1:0]};

    assign ARID    = MASTER_ID;
    assign ARADDR  = cur_addr;
    assign ARLEN   = DESC_ARLEN;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;
    assign RREADY  = (state == ST_R);

    // Error picture including the beat currently on the bus.
    always_comb begin
        err_now = err_flag;
        if (RRESP != AXI_RESP_OKAY)
            err_now = 1'b1;
        if (RLAST && beat != SEL_EOC)
            err_now = 1'b1;
        if (!RLAST && beat == SEL_EOC)
            err_now = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            dmaen_q       <= 1'b0;
            err_flag      <= 1'b0;
            eoc           <= 1'b0;
            beat          <= '0;
            cur_addr      <= '0;
            next_addr     <= '0;
            ARVALID       <= 1'b0;
            DESC_input    <= '0;
            DESC_sel      <= '0;
            DESC_write_en <= 1'b0;
            Start         <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            dmaen_q       <= DMAEN;
            DESC_write_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (DMAEN && !dmaen_q) begin
                        cur_addr <= {DESC_BASE[ADDR_W-1:2], 2'b00};
                        err_flag <= 1'b0;
                        ARVALID  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        beat    <= '0;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (RVALID) begin
                        DESC_input    <= RDATA;
                        DESC_sel      <= beat;
                        DESC_write_en <= (RRESP == AXI_RESP_OKAY) && !err_flag;
                        err_flag      <= err_now;
                        if (beat == SEL_NEXT)
                            next_addr <= {RDATA[ADDR_W-1:2], 2'b00};
                        if (beat == SEL_EOC)
                            eoc <= RDATA[0];
                        else
                            beat <= beat + 4'd1;
                        // Overlong bursts are drained here until RLAST shows up.
                        if (RLAST) begin
                            if (err_now) begin
                                busy  <= 1'b0;
                                err   <= 1'b1;
                                state <= ST_ERR;
                            end else if (!DMAEN) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_START;
                            end
                        end
                    end
                end
                ST_START: begin
                    Start <= 1'b1;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    Start <= 1'b0;
                    if (!DMAEN) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (Done) begin
                        if (eoc) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cur_addr <= next_addr;
                            ARVALID  <= 1'b1;
                            state    <= ST_AR;
                        end
                    end
                end
                ST_ERR: begin
                    if (!DMAEN) begin
                        err      <= 1'b0;
                        err_flag <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_fetch.sv
// Directed bench for dma_desc_fetch with a small AXI read slave and Done driver.
module tb_dma_desc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        DMAEN;
    logic [31:0] DESC_BASE;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] DESC_input;
    logic [3:0]  DESC_sel;
    logic        DESC_write_en;
    logic        Start;
    logic        Done;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    dma_desc_fetch dut (
        .clk(clk), .rst(rst), .DMAEN(DMAEN), .DESC_BASE(DESC_BASE),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .DESC_input(DESC_input), .DESC_sel(DESC_sel), .DESC_write_en(DESC_write_en),
        .Start(Start), .Done(Done), .busy(busy), .err(err)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mem [0:8191];
    exp_t        exp_tab [0:14];

    int          n_cmp  = 0;
    int          n_fail = 0;

    // Write/Start monitor, sampled on the falling edge.
    logic [3:0]  wr_sel [0:63];
    logic [31:0] wr_dat [0:63];
    int          wr_cnt      = 0;
    int          start_cnt   = 0;
    int          wr_at_start = 0;

    always @(negedge clk) begin
        if (DESC_write_en && wr_cnt < 64) begin
            wr_sel[wr_cnt] <= DESC_sel;
            wr_dat[wr_cnt] <= DESC_input;
            wr_cnt         <= wr_cnt + 1;
        end
        if (Start) begin
            start_cnt   <= start_cnt + 1;
            wr_at_start <= wr_cnt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic load_desc(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4);
        mem[(a >> 2) + 0] = w0;
        mem[(a >> 2) + 1] = w1;
        mem[(a >> 2) + 2] = w2;
        mem[(a >> 2) + 3] = w3;
        mem[(a >> 2) + 4] = w4;
    endtask

    // Serves one 5-beat burst; returns on the falling edge right after the last beat is taken.
    task automatic serve(input int ar_delay, input int gap, input int err_beat,
                         input int abort_beat, output logic [31:0] addr);
        int t;
        logic [31:0] a0;
        t = 0;
        while (!ARVALID && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("arvalid_wait");
        a0 = ARADDR;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            chk("ar_hold_valid", ARVALID, 1);
            chk("ar_hold_addr", ARADDR, a0);
        end
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        addr = a0;
        for (int b = 0; b < 5; b++) begin
            for (int g = 0; g < gap; g++) begin
                RVALID = 1'b0;
                @(negedge clk);
            end
            RVALID = 1'b1;
            RDATA  = mem[(a0 >> 2) + 32'(b)];
            RLAST  = (b == 4);
            RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
            t = 0;
            while (!RREADY && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) fail_now("rready_wait");
            @(negedge clk);
            if (b == abort_beat) DMAEN = 1'b0;
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (!Start && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("start_wait");
    endtask

    task automatic pulse_done();
        Done = 1'b1;
        @(negedge clk);
        Done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran too long");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int base_wr, base_st;

        exp_tab[0]  = '{4'd0, 32'h100};
        exp_tab[1]  = '{4'd1, 32'h200};
        exp_tab[2]  = '{4'd2, 32'h40};
        exp_tab[3]  = '{4'd3, 32'h0};
        exp_tab[4]  = '{4'd4, 32'h1};
        exp_tab[5]  = '{4'd0, 32'h111};
        exp_tab[6]  = '{4'd1, 32'h222};
        exp_tab[7]  = '{4'd2, 32'h33};
        exp_tab[8]  = '{4'd3, 32'h2003};
        exp_tab[9]  = '{4'd4, 32'h0};
        exp_tab[10] = '{4'd0, 32'hAAA};
        exp_tab[11] = '{4'd1, 32'hBBB};
        exp_tab[12] = '{4'd2, 32'hCC};
        exp_tab[13] = '{4'd3, 32'h0};
        exp_tab[14] = '{4'd4, 32'h1};

        rst = 1'b0; DMAEN = 1'b0; DESC_BASE = '0; ARREADY = 1'b0; RID = '0;
        RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0; Done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_wr_en", DESC_write_en, 0);
        chk("rst_input", DESC_input, 0);
        chk("rst_sel", DESC_sel, 0);
        chk("rst_start", Start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_araddr", ARADDR, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("arid", ARID, 4'd2);
        chk("arlen", ARLEN, 4'd4);
        chk("arsize", ARSIZE, 3'b010);
        chk("arburst", ARBURST, 2'b01);

        // Single descriptor
        load_desc(32'h1000, 32'h100, 32'h200, 32'h40, 32'h0, 32'h1);
        base_wr = wr_cnt; base_st = start_cnt;
        DESC_BASE = 32'h1000;
        DMAEN = 1'b1;
        @(negedge clk);
        chk("t1_arvalid_lat", ARVALID, 1);
        chk("t1_araddr", ARADDR, 32'h1000);
        chk("t1_busy", busy, 1);
        serve(0, 0, -1, -1, a);
        chk("t1_start_early", Start, 0);
        @(negedge clk);
        chk("t1_start_lat", Start, 1);
        @(negedge clk);
        chk("t1_start_pulse", Start, 0);
        pulse_done();
        chk("t1_busy_end", busy, 0);
        repeat (3) @(negedge clk);
        chk("t1_held_idle", ARVALID, 0);
        chk("t1_wr_cnt", wr_cnt - base_wr, 5);
        chk("t1_start_cnt", start_cnt - base_st, 1);
        chk("t1_wr_before_start", wr_at_start - base_wr, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t1_sel", wr_sel[base_wr + i], exp_tab[i].sel);
            chk("t1_data", wr_dat[base_wr + i], exp_tab[i].data);
        end
        DMAEN = 1'b0;
        @(negedge clk);

        // Two-descriptor chain
        load_desc(32'h1000, 32'h111, 32'h222, 32'h33, 32'h2003, 32'h0);
        load_desc(32'h2000, 32'hAAA, 32'hBBB, 32'hCC, 32'h0, 32'h1);
        base_wr = wr_cnt; base_st = start_cnt;
        DMAEN = 1'b1;
        serve(0, 0, -1, -1, a);
        chk("t2_araddr0", a, 32'h1000);
        wait_start();
        pulse_done();
        chk("t2_done_to_ar", ARVALID, 1);
        chk("t2_busy_mid", busy, 1);
        serve(0, 0, -1, -1, a);
        chk("t2_araddr1", a, 32'h2000);
        wait_start();
        @(negedge clk);
        pulse_done();
        chk("t2_busy_end", busy, 0);
        @(negedge clk);
        chk("t2_start_cnt", start_cnt - base_st, 2);
        chk("t2_wr_cnt", wr_cnt - base_wr, 10);
        for (int i = 0; i < 10; i++) begin
            chk("t2_sel", wr_sel[base_wr + i], exp_tab[5 + i].sel);
            chk("t2_data", wr_dat[base_wr + i], exp_tab[5 + i].data);
        end
        DMAEN = 1'b0;
        @(negedge clk);

        // Backpressure on AR and R
        load_desc(32'h3000, 32'h1, 32'h2, 32'h3, 32'h0, 32'h1);
        base_wr = wr_cnt; base_st = start_cnt;
        DESC_BASE = 32'h3000;
        DMAEN = 1'b1;
        serve(3, 2, -1, -1, a);
        chk("t3_araddr", a, 32'h3000);
        wait_start();
        @(negedge clk);
        pulse_done();
        @(negedge clk);
        chk("t3_wr_cnt", wr_cnt - base_wr, 5);
        chk("t3_start_cnt", start_cnt - base_st, 1);
        for (int i = 0; i < 5; i++)
            chk("t3_sel_order", wr_sel[base_wr + i], i);
        DMAEN = 1'b0;
        @(negedge clk);

        // SLVERR on beat 2
        load_desc(32'h4000, 32'h10, 32'h20, 32'h30, 32'h0, 32'h1);
        base_wr = wr_cnt; base_st = start_cnt;
        DESC_BASE = 32'h4000;
        DMAEN = 1'b1;
        serve(0, 0, 2, -1, a);
        @(negedge clk);
        chk("t4_err", err, 1);
        chk("t4_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", err, 1);
        chk("t4_no_start", start_cnt - base_st, 0);
        chk("t4_wr_cnt", wr_cnt - base_wr, 2);
        chk("t4_sel0", wr_sel[base_wr], 0);
        chk("t4_sel1", wr_sel[base_wr + 1], 1);
        DMAEN = 1'b0;
        @(negedge clk);
        chk("t4_err_clear", err, 0);
        @(negedge clk);

        // DMAEN dropped mid-burst, then restart from a new base
        load_desc(32'h5000, 32'h51, 32'h52, 32'h53, 32'h0, 32'h0);
        load_desc(32'h6000, 32'h61, 32'h62, 32'h63, 32'h0, 32'h1);
        base_wr = wr_cnt; base_st = start_cnt;
        DESC_BASE = 32'h5000;
        DMAEN = 1'b1;
        serve(0, 0, -1, 1, a);
        chk("t5_busy_abort", busy, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_start", start_cnt - base_st, 0);
        chk("t5_arvalid", ARVALID, 0);
        chk("t5_wr_drained", wr_cnt - base_wr, 5);
        DESC_BASE = 32'h6002;
        DMAEN = 1'b1;
        @(negedge clk);
        chk("t5_restart_arvalid", ARVALID, 1);
        chk("t5_restart_addr", ARADDR, 32'h6000);
        serve(0, 0, -1, -1, a);
        wait_start();
        @(negedge clk);
        pulse_done();
        chk("t5_busy_end", busy, 0);
        @(negedge clk);
        chk("t5_start_cnt", start_cnt - base_st, 1);
        chk("t5_last_data", wr_dat[base_wr + 9], 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
